// File: rtl/dmem_responder_if.sv
// Request/response bus between the Memory stage and the data-memory responder.
// master = core side (issues requests, takes responses); slave = responder side.
interface dmem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_wstrb;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder for the Memory stage: one outstanding load/store at a time,
// byte-strobed word storage, LATENCY wait cycles between accept and response.
// Optional feature macro: DMEM_ERR_CHECK_EN -- flags misaligned / out-of-range accesses
// on rsp_err and suppresses their memory effect. Without it, addresses wrap modulo DEPTH.
module dmem_responder #(
   parameter int          DEPTH     = 1024,
   parameter int          LATENCY   = 2,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst,
   dmem_responder_if.slave   bus
);
   localparam int          AW        = $clog2(DEPTH);
   localparam logic [1:0]  ST_IDLE   = 2'd0;
   localparam logic [1:0]  ST_WAIT   = 2'd1;
   localparam logic [1:0]  ST_RESP   = 2'd2;
   localparam logic [3:0]  WAIT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

   logic [1:0]    state;
   logic [3:0]    wait_cnt;
   logic          cap_we;
   logic [31:0]   cap_addr;
   logic [31:0]   cap_wdata;
   logic [3:0]    cap_wstrb;
   logic          rsp_valid;
   logic [31:0]   rsp_rdata;
   logic          rsp_err;

   logic          acc_we;
   logic [31:0]   acc_addr;
   logic [31:0]   acc_wdata;
   logic [3:0]    acc_wstrb;
   logic          acc_err;
   logic [AW-1:0] idx;
   logic          enter_resp;
   logic [31:0]   load_data;

   logic [31:0]   mem [DEPTH];

   assign bus.req_ready = (state == ST_IDLE);
   assign bus.rsp_valid = rsp_valid;
   assign bus.rsp_rdata = rsp_rdata;
   assign bus.rsp_err   = rsp_err;

   // Select the access being performed: live request in IDLE (zero-latency path), captured one otherwise
   always_comb begin
      if (state == ST_IDLE) begin
         acc_we    = bus.req_we;
         acc_addr  = bus.req_addr;
         acc_wdata = bus.req_wdata;
         acc_wstrb = bus.req_wstrb;
      end else begin
         acc_we    = cap_we;
         acc_addr  = cap_addr;
         acc_wdata = cap_wdata;
         acc_wstrb = cap_wstrb;
      end
   end

   // Word index and error classification of the selected access
   always_comb begin
      idx = AW'((acc_addr - BASE_ADDR) >> 2);
`ifdef DMEM_ERR_CHECK_EN
      // Addresses below BASE_ADDR wrap to large offsets and fail the range test too
      if ((acc_addr[1:0] != 2'b00) ||
          ({1'b0, acc_addr - BASE_ADDR} >= 33'(64'(DEPTH) * 64'd4))) begin
         acc_err = 1'b1;
      end else begin
         acc_err = 1'b0;
      end
`else
      acc_err = 1'b0;
`endif
   end

   // Detect the edge that moves into RESP; that edge performs the memory access
   always_comb begin
      enter_resp = 1'b0;
      if ((state == ST_IDLE) && bus.req_valid && (LATENCY == 0)) begin
         enter_resp = 1'b1;
      end else if ((state == ST_WAIT) && (wait_cnt == 4'd0)) begin
         enter_resp = 1'b1;
      end else begin
         enter_resp = 1'b0;
      end
   end

   // Response data: stores and erroring loads return zero
   always_comb begin
      if (acc_we || acc_err) begin
         load_data = 32'h0000_0000;
      end else begin
         load_data = mem[idx];
      end
   end

   // Commit enabled store bytes on the RESP-entry edge; the array itself is never reset
   always_ff @(posedge clk) begin
      if (rst && enter_resp && acc_we && !acc_err) begin
         for (int i = 0; i < 4; i++) begin
            if (acc_wstrb[i]) begin
               mem[idx][8*i +: 8] <= acc_wdata[8*i +: 8];
            end
         end
      end
   end

   // Transaction FSM: accept in IDLE, count wait states, hold the response until taken
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         wait_cnt  <= 4'd0;
         cap_we    <= 1'b0;
         cap_addr  <= 32'h0000_0000;
         cap_wdata <= 32'h0000_0000;
         cap_wstrb <= 4'h0;
         rsp_valid <= 1'b0;
         rsp_rdata <= 32'h0000_0000;
         rsp_err   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.req_valid) begin
                  cap_we    <= bus.req_we;
                  cap_addr  <= bus.req_addr;
                  cap_wdata <= bus.req_wdata;
                  cap_wstrb <= bus.req_wstrb;
                  if (enter_resp) begin
                     state     <= ST_RESP;
                     rsp_valid <= 1'b1;
                     rsp_rdata <= load_data;
                     rsp_err   <= acc_err;
                  end else begin
                     state    <= ST_WAIT;
                     wait_cnt <= WAIT_INIT;
                  end
               end
            end
            ST_WAIT: begin
               if (enter_resp) begin
                  state     <= ST_RESP;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= load_data;
                  rsp_err   <= acc_err;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            ST_RESP: begin
               if (bus.rsp_ready) begin
                  state     <= ST_IDLE;
                  rsp_valid <= 1'b0;
                  rsp_rdata <= 32'h0000_0000;
                  rsp_err   <= 1'b0;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end
endmodule
